mw_wb_stage: RTL and testbench

MW_WB_STAGE -- requirements
Module: mw_wb_stage

---
 rtl/mw_wb_stage.sv | 160 ++++++++++++++++
 tb/tb_mw_wb_stage.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/mw_wb_stage.sv
// mw_wb_stage -- write-back (W) pipeline stage.
//
// Captures the M-stage instruction on each rising edge. It then produces the
// register-file write address, write data, write enable and tracing PC from
// the captured values. The write data is combinational from the W registers,
// so it is also used as the W-stage forwarding value.
//
// Optional feature macro: MW_LOAD_EXT_EN
//   defined   : sub-word loads (LB/LBU/LH/LHU) are extracted and extended,
//               and misaligned loads are flagged and their write is suppressed.
//   undefined : m_load_type and m_byte_off are ignored, a MEM source passes
//               the raw word, and w_misalign is tied low.
//
// Ports
//   clk, rst        clock; synchronous active-high reset
//   stall, flush    hold W contents / load a bubble (flush has priority)
//   m_valid         M-stage instruction is real
//   m_pc            M-stage instruction address
//   m_rd            M-stage destination register
//   m_reg_we        M-stage instruction writes the register file
//   m_wb_sel        write-data source: 00 ALU, 01 MEM, 10 link, 11 reserved
//   m_alu_res       ALU result
//   m_mem_rdata     raw aligned data-memory word
//   m_load_type     0 LW, 1 LB, 2 LBU, 3 LH, 4 LHU (others as LW)
//   m_byte_off      load address bits [1:0]
//   w_a3, w_wd      register-file write address / write data
//   w_pc            W-stage instruction address
//   w_grf_we        register-file write enable
//   w_valid         W stage holds a real instruction
//   w_misalign      W-stage load is misaligned
module mw_wb_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        m_valid,
    input  logic [31:0] m_pc,
    input  logic [4:0]  m_rd,
    input  logic        m_reg_we,
    input  logic [1:0]  m_wb_sel,
    input  logic [31:0] m_alu_res,
    input  logic [31:0] m_mem_rdata,
    input  logic [2:0]  m_load_type,
    input  logic [1:0]  m_byte_off,
    output logic [4:0]  w_a3,
    output logic [31:0] w_wd,
    output logic [31:0] w_pc,
    output logic        w_grf_we,
    output logic        w_valid,
    output logic        w_misalign
);

    localparam logic [1:0] SEL_ALU  = 2'b00;
    localparam logic [1:0] SEL_MEM  = 2'b01;
    localparam logic [1:0] SEL_LINK = 2'b10;

    logic        r_valid;
    logic [31:0] r_pc;
    logic [4:0]  r_rd;
    logic        r_reg_we;
    logic [1:0]  r_wb_sel;
    logic [31:0] r_alu_res;
    logic [31:0] r_mem_rdata;
    logic [31:0] w_mem_data;

    // A bubble is loaded on reset, on flush, and when M carries no instruction.
    always_ff @(posedge clk) begin
        if (rst || flush || (!stall && !m_valid)) begin
            r_valid     <= 1'b0;
            r_pc        <= RESET_PC;
            r_rd        <= 5'd0;
            r_reg_we    <= 1'b0;
            r_wb_sel    <= SEL_ALU;
            r_alu_res   <= 32'd0;
            r_mem_rdata <= 32'd0;
        end else if (!stall) begin
            r_valid     <= 1'b1;
            r_pc        <= m_pc;
            r_rd        <= m_rd;
            r_reg_we    <= m_reg_we;
            r_wb_sel    <= m_wb_sel;
            r_alu_res   <= m_alu_res;
            r_mem_rdata <= m_mem_rdata;
        end
    end

`ifdef MW_LOAD_EXT_EN
    logic [2:0] r_load_type;
    logic [1:0] r_byte_off;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_ff @(posedge clk) begin
        if (rst || flush || (!stall && !m_valid)) begin
            r_load_type <= 3'd0;
            r_byte_off  <= 2'd0;
        end else if (!stall) begin
            r_load_type <= m_load_type;
            r_byte_off  <= m_byte_off;
        end
    end

    always_comb begin
        w_byte = 8'd0;
        case (r_byte_off)
            2'd0:    w_byte = r_mem_rdata[7:0];
            2'd1:    w_byte = r_mem_rdata[15:8];
            2'd2:    w_byte = r_mem_rdata[23:16];
            default: w_byte = r_mem_rdata[31:24];
        endcase
        w_half = r_byte_off[1] ? r_mem_rdata[31:16] : r_mem_rdata[15:0];

        w_mem_data = r_mem_rdata;
        case (r_load_type)
            3'd1:    w_mem_data = {{24{w_byte[7]}}, w_byte};
            3'd2:    w_mem_data = {24'd0, w_byte};
            3'd3:    w_mem_data = {{16{w_half[15]}}, w_half};
            3'd4:    w_mem_data = {16'd0, w_half};
            default: w_mem_data = r_mem_rdata;
        endcase
    end

    // Halfword loads need bit 0 clear; LW (and unknown codes) need word alignment.
    always_comb begin
        w_misalign = 1'b0;
        if (r_valid && (r_wb_sel == SEL_MEM)) begin
            case (r_load_type)
                3'd1, 3'd2: w_misalign = 1'b0;
                3'd3, 3'd4: w_misalign = r_byte_off[0];
                default:    w_misalign = (r_byte_off != 2'd0);
            endcase
        end
    end
`else
    // Inputs consumed here only so lint sees them as intentionally unused.
    logic w_unused_load_cfg;
    assign w_unused_load_cfg = ^{m_load_type, m_byte_off};
    assign w_mem_data = r_mem_rdata;
    assign w_misalign = 1'b0;
`endif

    always_comb begin
        w_wd = 32'd0;
        case (r_wb_sel)
            SEL_ALU:  w_wd = r_alu_res;
            SEL_MEM:  w_wd = w_mem_data;
            SEL_LINK: w_wd = r_pc + 32'd8;
            default:  w_wd = 32'd0;
        endcase
    end

    assign w_a3     = r_rd;
    assign w_pc     = r_pc;
    assign w_valid  = r_valid;
    assign w_grf_we = r_valid & r_reg_we & (r_rd != 5'd0) & ~w_misalign
                      & (r_wb_sel != 2'b11);

endmodule

// File: tb/tb_mw_wb_stage.sv
module tb_mw_wb_stage;

    logic        clk = 1'b0;
    logic        rst, stall, flush, m_valid, m_reg_we;
    logic [31:0] m_pc, m_alu_res, m_mem_rdata;
    logic [4:0]  m_rd;
    logic [1:0]  m_wb_sel, m_byte_off;
    logic [2:0]  m_load_type;
    logic [4:0]  w_a3;
    logic [31:0] w_wd, w_pc;
    logic        w_grf_we, w_valid, w_misalign;

    int checks = 0;
    int errors = 0;

`ifdef MW_LOAD_EXT_EN
    localparam bit EXT = 1'b1;
`else
    localparam bit EXT = 1'b0;
`endif

    localparam logic [31:0] RAW = 32'h80FF_7F01;

    always #5 clk = ~clk;

    mw_wb_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .m_valid(m_valid), .m_pc(m_pc), .m_rd(m_rd), .m_reg_we(m_reg_we),
        .m_wb_sel(m_wb_sel), .m_alu_res(m_alu_res), .m_mem_rdata(m_mem_rdata),
        .m_load_type(m_load_type), .m_byte_off(m_byte_off),
        .w_a3(w_a3), .w_wd(w_wd), .w_pc(w_pc), .w_grf_we(w_grf_we),
        .w_valid(w_valid), .w_misalign(w_misalign)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] pc, input logic [4:0] rd, input logic we,
                         input logic [1:0] sel, input logic [31:0] alu,
                         input logic [31:0] mem, input logic [2:0] lt,
                         input logic [1:0] off);
        m_valid = 1'b1; m_pc = pc; m_rd = rd; m_reg_we = we; m_wb_sel = sel;
        m_alu_res = alu; m_mem_rdata = mem; m_load_type = lt; m_byte_off = off;
    endtask

    task automatic chk_bubble(input string tag);
        chk({tag, "_valid"}, {31'd0, w_valid}, 32'd0);
        chk({tag, "_we"},    {31'd0, w_grf_we}, 32'd0);
        chk({tag, "_a3"},    {27'd0, w_a3}, 32'd0);
        chk({tag, "_wd"},    w_wd, 32'd0);
        chk({tag, "_pc"},    w_pc, 32'h0000_3000);
        chk({tag, "_mis"},   {31'd0, w_misalign}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        drive(32'h0000_1234, 5'd9, 1'b1, 2'b00, 32'h1111_1111, 32'h2222_2222, 3'd0, 2'd0);
        #2;
        step();
        chk_bubble("reset");
        rst = 1'b0;

        // ALU result write
        drive(32'h0000_3004, 5'd8, 1'b1, 2'b00, 32'h1234_5678, 32'h0, 3'd0, 2'd0);
        step();
        chk("alu_a3", {27'd0, w_a3}, 32'd8);
        chk("alu_wd", w_wd, 32'h1234_5678);
        chk("alu_we", {31'd0, w_grf_we}, 32'd1);
        chk("alu_valid", {31'd0, w_valid}, 32'd1);
        chk("alu_pc", w_pc, 32'h0000_3004);

        // Sub-word loads
        drive(32'h0000_3008, 5'd9, 1'b1, 2'b01, 32'h0, RAW, 3'd1, 2'd3);
        step();
        chk("lb_wd", w_wd, EXT ? 32'hFFFF_FF80 : RAW);
        chk("lb_we", {31'd0, w_grf_we}, 32'd1);

        drive(32'h0000_3008, 5'd9, 1'b1, 2'b01, 32'h0, RAW, 3'd2, 2'd3);
        step();
        chk("lbu_wd", w_wd, EXT ? 32'h0000_0080 : RAW);

        drive(32'h0000_300C, 5'd10, 1'b1, 2'b01, 32'h0, RAW, 3'd3, 2'd1);
        step();
        chk("lh_mis", {31'd0, w_misalign}, EXT ? 32'd1 : 32'd0);
        chk("lh_we", {31'd0, w_grf_we}, EXT ? 32'd0 : 32'd1);
        chk("lh_wd", w_wd, EXT ? 32'h0000_7F01 : RAW);

        drive(32'h0000_300C, 5'd10, 1'b1, 2'b01, 32'h0, RAW, 3'd4, 2'd2);
        step();
        chk("lhu_wd", w_wd, EXT ? 32'h0000_80FF : RAW);
        chk("lhu_mis", {31'd0, w_misalign}, 32'd0);

        drive(32'h0000_300C, 5'd11, 1'b1, 2'b01, 32'h0, RAW, 3'd0, 2'd2);
        step();
        chk("lw_off2_mis", {31'd0, w_misalign}, EXT ? 32'd1 : 32'd0);
        chk("lw_off2_we", {31'd0, w_grf_we}, EXT ? 32'd0 : 32'd1);

        // Unknown load code behaves as LW
        drive(32'h0000_300C, 5'd11, 1'b1, 2'b01, 32'h0, RAW, 3'd7, 2'd0);
        step();
        chk("lt7_wd", w_wd, RAW);
        chk("lt7_mis", {31'd0, w_misalign}, 32'd0);

        // Link
        drive(32'h0000_3010, 5'd31, 1'b1, 2'b10, 32'h0, 32'h0, 3'd0, 2'd0);
        step();
        chk("jal_wd", w_wd, 32'h0000_3018);
        chk("jal_we", {31'd0, w_grf_we}, 32'd1);
        chk("jal_a3", {27'd0, w_a3}, 32'd31);

        drive(32'hFFFF_FFFC, 5'd31, 1'b1, 2'b10, 32'h0, 32'h0, 3'd0, 2'd0);
        step();
        chk("link_wrap_wd", w_wd, 32'h0000_0004);

        // Reserved source
        drive(32'h0000_3014, 5'd5, 1'b1, 2'b11, 32'h5555_5555, RAW, 3'd0, 2'd0);
        step();
        chk("sel11_wd", w_wd, 32'd0);
        chk("sel11_we", {31'd0, w_grf_we}, 32'd0);

        // Write to $0
        drive(32'h0000_3018, 5'd0, 1'b1, 2'b00, 32'h0000_AAAA, 32'h0, 3'd0, 2'd0);
        step();
        chk("r0_we", {31'd0, w_grf_we}, 32'd0);
        chk("r0_a3", {27'd0, w_a3}, 32'd0);
        chk("r0_wd", w_wd, 32'h0000_AAAA);

        // Stall for three cycles while M changes
        drive(32'h0000_301C, 5'd7, 1'b1, 2'b00, 32'hDEAD_BEEF, 32'h0, 3'd0, 2'd0);
        step();
        stall = 1'b1;
        drive(32'h0000_4000, 5'd12, 1'b0, 2'b10, 32'h0BAD_0BAD, 32'h0, 3'd0, 2'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_a3", {27'd0, w_a3}, 32'd7);
            chk("stall_wd", w_wd, 32'hDEAD_BEEF);
            chk("stall_pc", w_pc, 32'h0000_301C);
            chk("stall_we", {31'd0, w_grf_we}, 32'd1);
        end

        // Stall and flush together
        flush = 1'b1;
        step();
        chk_bubble("stall_flush");
        stall = 1'b0; flush = 1'b0;

        // Invalid M instruction
        drive(32'h0000_5000, 5'd3, 1'b1, 2'b00, 32'h0000_0005, 32'h0, 3'd0, 2'd0);
        m_valid = 1'b0;
        step();
        chk_bubble("mvalid0");

        // Reset during a stall with an LW held
        drive(32'h0000_3020, 5'd4, 1'b1, 2'b01, 32'h0, 32'hCAFE_F00D, 3'd0, 2'd0);
        step();
        chk("lw_wd", w_wd, 32'hCAFE_F00D);
        chk("lw_we", {31'd0, w_grf_we}, 32'd1);
        stall = 1'b1;
        step();
        chk("lw_hold_wd", w_wd, 32'hCAFE_F00D);
        rst = 1'b1;
        step();
        chk_bubble("rst_in_stall");
        rst = 1'b0;
        m_valid = 1'b0;
        step();
        chk("after_rst_we", {31'd0, w_grf_we}, 32'd0);
        chk("after_rst_valid", {31'd0, w_valid}, 32'd0);
        stall = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
